reg_access_master: RTL and testbench

- Responder end of the register-access handshake that the init sequencer drives with write_start/read_start.
- Accepts one 32-bit register read or write request at a time and executes it as a single AXI4-Lite master transaction (XDMA or BAR space).
- Returns read data and a one-cycle done pulse to the requester.
- Sits between the init sequencer and the AXI interconnect.

---
 rtl/reg_access_pkg.sv | 26 ++
 rtl/axil_phase_timer.sv | 32 +++
 rtl/reg_access_master.sv | 223 ++++++++++++++++++++++
 tb/tb_reg_access_master.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_access_pkg.sv
// Shared encodings for the register-access AXI4-Lite master: FSM states,
// AXI response codes and the data value returned by a timed-out read.
package reg_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0]  RESP_OKAY       = 2'b00;
    localparam logic [1:0]  RESP_SLVERR     = 2'b10;
    localparam logic [1:0]  RESP_DECERR     = 2'b11;

    localparam logic [31:0] RD_TIMEOUT_DATA = 32'hFFFF_FFFF;
    localparam logic [3:0]  WSTRB_FULL      = 4'hF;
    localparam logic [2:0]  AXI_PROT        = 3'b000;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_phase_timer.sv
// Cycle counter for one AXI phase; expired is high in the last allowed cycle
// of a phase, i.e. when the count has reached TIMEOUT_CYCLES-1.
module axil_phase_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its inputs, independent of block evaluation order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (!run || clear) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/reg_access_master.sv
// Executes one register read or write request at a time as a single
// AXI4-Lite transaction, with per-phase timeout and sticky error flags.
module reg_access_master
    import reg_access_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic                  write_start,
    input  logic                  read_start,
    output logic                  write_start_ack,
    output logic                  read_start_ack,
    input  logic [ADDR_WIDTH-1:0] reg_addr,
    input  logic [31:0]           reg_wdata,
    output logic [31:0]           reg_rdata,
    output logic                  write_done,
    output logic                  read_done,
    output logic                  resp_err,
    output logic                  timeout_err,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [31:0]           m_axil_wdata,
    output logic [3:0]            m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [31:0]           m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    state_t state;
    logic   aw_done;
    logic   w_done;

    logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic   phase_run;
    logic   phase_end;
    logic   timer_expired;

    assign m_axil_awprot = AXI_PROT;
    assign m_axil_arprot = AXI_PROT;

    assign aw_hs = m_axil_awvalid && m_axil_awready;
    assign w_hs  = m_axil_wvalid  && m_axil_wready;
    assign b_hs  = m_axil_bvalid  && m_axil_bready;
    assign ar_hs = m_axil_arvalid && m_axil_arready;
    assign r_hs  = m_axil_rvalid  && m_axil_rready;

    assign phase_run = (state == ST_WR_REQ) || (state == ST_WR_RESP) ||
                       (state == ST_RD_REQ) || (state == ST_RD_RESP);

    // NOTE: give every always_comb output a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        phase_end = 1'b0;
        unique case (state)
            ST_WR_REQ:  phase_end = (aw_done || aw_hs) && (w_done || w_hs);
            ST_WR_RESP: phase_end = b_hs;
            ST_RD_REQ:  phase_end = ar_hs;
            ST_RD_RESP: phase_end = r_hs;
            default:    phase_end = 1'b0;
        endcase
    end

    // Every phase exit (normal or timed-out) is a state change, so the
    // counter restarts from zero in the next phase.
    axil_phase_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_phase_timer (
        .aclk    (aclk),
        .aresetn (aresetn),
        .run     (phase_run),
        .clear   (phase_end || timer_expired),
        .expired (timer_expired)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state           <= ST_IDLE;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            write_start_ack <= 1'b0;
            read_start_ack  <= 1'b0;
            write_done      <= 1'b0;
            read_done       <= 1'b0;
            reg_rdata       <= '0;
            resp_err        <= 1'b0;
            timeout_err     <= 1'b0;
            m_axil_awaddr   <= '0;
            m_axil_awvalid  <= 1'b0;
            m_axil_wdata    <= '0;
            m_axil_wstrb    <= '0;
            m_axil_wvalid   <= 1'b0;
            m_axil_bready   <= 1'b0;
            m_axil_araddr   <= '0;
            m_axil_arvalid  <= 1'b0;
            m_axil_rready   <= 1'b0;
        end else begin
            write_start_ack <= 1'b0;
            read_start_ack  <= 1'b0;
            write_done      <= 1'b0;
            read_done       <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (write_start) begin
                        write_start_ack <= 1'b1;
                        m_axil_awaddr   <= reg_addr;
                        m_axil_wdata    <= reg_wdata;
                        m_axil_wstrb    <= WSTRB_FULL;
                        m_axil_awvalid  <= 1'b1;
                        m_axil_wvalid   <= 1'b1;
                        aw_done         <= 1'b0;
                        w_done          <= 1'b0;
                        state           <= ST_WR_REQ;
                    end else if (read_start) begin
                        read_start_ack  <= 1'b1;
                        m_axil_araddr   <= reg_addr;
                        m_axil_arvalid  <= 1'b1;
                        state           <= ST_RD_REQ;
                    end
                end

                // AW and W complete independently; remember which one is done.
                ST_WR_REQ: begin
                    if (phase_end) begin
                        m_axil_awvalid <= 1'b0;
                        m_axil_wvalid  <= 1'b0;
                        m_axil_bready  <= 1'b1;
                        state          <= ST_WR_RESP;
                    end else if (timer_expired) begin
                        m_axil_awvalid <= 1'b0;
                        m_axil_wvalid  <= 1'b0;
                        timeout_err    <= 1'b1;
                        write_done     <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        if (aw_hs) begin
                            m_axil_awvalid <= 1'b0;
                            aw_done        <= 1'b1;
                        end
                        if (w_hs) begin
                            m_axil_wvalid  <= 1'b0;
                            w_done         <= 1'b1;
                        end
                    end
                end

                ST_WR_RESP: begin
                    if (b_hs) begin
                        m_axil_bready <= 1'b0;
                        if (resp_is_error(m_axil_bresp)) begin
                            resp_err <= 1'b1;
                        end
                        write_done    <= 1'b1;
                        state         <= ST_DONE;
                    end else if (timer_expired) begin
                        m_axil_bready <= 1'b0;
                        timeout_err   <= 1'b1;
                        write_done    <= 1'b1;
                        state         <= ST_DONE;
                    end
                end

                ST_RD_REQ: begin
                    if (ar_hs) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= ST_RD_RESP;
                    end else if (timer_expired) begin
                        m_axil_arvalid <= 1'b0;
                        timeout_err    <= 1'b1;
                        reg_rdata      <= RD_TIMEOUT_DATA;
                        read_done      <= 1'b1;
                        state          <= ST_DONE;
                    end
                end

                // Read data is captured even on an error response.
                ST_RD_RESP: begin
                    if (r_hs) begin
                        m_axil_rready <= 1'b0;
                        reg_rdata     <= m_axil_rdata;
                        if (resp_is_error(m_axil_rresp)) begin
                            resp_err <= 1'b1;
                        end
                        read_done     <= 1'b1;
                        state         <= ST_DONE;
                    end else if (timer_expired) begin
                        m_axil_rready <= 1'b0;
                        timeout_err   <= 1'b1;
                        reg_rdata     <= RD_TIMEOUT_DATA;
                        read_done     <= 1'b1;
                        state         <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_master.sv
// Randomized bench: acts as requester and AXI4-Lite slave, and predicts each
// transaction's outcome from the request, slave delays and response codes.
module tb_reg_access_master;
    import reg_access_pkg::*;

    localparam int ADDR_W  = 64;
    localparam int TIMEOUT = 32;
    localparam int NEVER   = 1_000_000;
    localparam int BUDGET  = 5 * TIMEOUT + 40;

    logic              aclk;
    logic              aresetn;
    logic              write_start, read_start;
    logic              write_start_ack, read_start_ack;
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_wdata, reg_rdata;
    logic              write_done, read_done, resp_err, timeout_err;
    logic [ADDR_W-1:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]        m_axil_awprot, m_axil_arprot;
    logic              m_axil_awvalid, m_axil_awready;
    logic [31:0]       m_axil_wdata;
    logic [3:0]        m_axil_wstrb;
    logic              m_axil_wvalid, m_axil_wready;
    logic [1:0]        m_axil_bresp;
    logic              m_axil_bvalid, m_axil_bready;
    logic              m_axil_arvalid, m_axil_arready;
    logic [31:0]       m_axil_rdata;
    logic [1:0]        m_axil_rresp;
    logic              m_axil_rvalid, m_axil_rready;

    reg_access_master #(
        .ADDR_WIDTH     (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .write_start     (write_start),
        .read_start      (read_start),
        .write_start_ack (write_start_ack),
        .read_start_ack  (read_start_ack),
        .reg_addr        (reg_addr),
        .reg_wdata       (reg_wdata),
        .reg_rdata       (reg_rdata),
        .write_done      (write_done),
        .read_done       (read_done),
        .resp_err        (resp_err),
        .timeout_err     (timeout_err),
        .m_axil_awaddr   (m_axil_awaddr),
        .m_axil_awprot   (m_axil_awprot),
        .m_axil_awvalid  (m_axil_awvalid),
        .m_axil_awready  (m_axil_awready),
        .m_axil_wdata    (m_axil_wdata),
        .m_axil_wstrb    (m_axil_wstrb),
        .m_axil_wvalid   (m_axil_wvalid),
        .m_axil_wready   (m_axil_wready),
        .m_axil_bresp    (m_axil_bresp),
        .m_axil_bvalid   (m_axil_bvalid),
        .m_axil_bready   (m_axil_bready),
        .m_axil_araddr   (m_axil_araddr),
        .m_axil_arprot   (m_axil_arprot),
        .m_axil_arvalid  (m_axil_arvalid),
        .m_axil_arready  (m_axil_arready),
        .m_axil_rdata    (m_axil_rdata),
        .m_axil_rresp    (m_axil_rresp),
        .m_axil_rvalid   (m_axil_rvalid),
        .m_axil_rready   (m_axil_rready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration for the current transaction.
    int          aw_delay, w_delay, b_delay, ar_delay, r_delay;
    logic [1:0]  bresp_cfg, rresp_cfg;
    logic [31:0] rdata_cfg;

    // Slave bookkeeping and observations.
    int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          b_pending, r_pending, b_hs_next, r_hs_next;
    logic [63:0] seen_awaddr, seen_araddr;
    logic [31:0] seen_wdata;
    logic [3:0]  seen_wstrb;
    int          stable_viol;
    bit          prev_awvalid, prev_aw_hs, prev_wvalid, prev_w_hs, prev_arvalid, prev_ar_hs;
    logic [63:0] prev_awaddr, prev_araddr;
    logic [31:0] prev_wdata;

    // Requester-side observations.
    int          cyc;
    int          n_wack, n_rack, n_wdone, n_rdone, overlap;
    int          wack_cyc, rack_cyc, wdone_cyc, rdone_cyc;
    logic [31:0] rdata_at_done;

    // Reference model state.
    bit          resp_err_m, timeout_err_m;
    logic [31:0] rdata_m;

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    endtask

    task automatic slave_clear();
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_arready = 1'b0;
        m_axil_bvalid  = 1'b0; m_axil_bresp  = 2'b00;
        m_axil_rvalid  = 1'b0; m_axil_rresp  = 2'b00; m_axil_rdata = '0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        b_pending = 0; r_pending = 0; b_hs_next = 0; r_hs_next = 0;
        seen_awaddr = '0; seen_araddr = '0; seen_wdata = '0; seen_wstrb = '0;
        stable_viol = 0;
        prev_awvalid = 0; prev_aw_hs = 0; prev_wvalid = 0; prev_w_hs = 0;
        prev_arvalid = 0; prev_ar_hs = 0;
        prev_awaddr = '0; prev_araddr = '0; prev_wdata = '0;
        n_wack = 0; n_rack = 0; n_wdone = 0; n_rdone = 0; overlap = 0;
        wack_cyc = 0; rack_cyc = 0; wdone_cyc = 0; rdone_cyc = 0;
        rdata_at_done = '0;
    endtask

    // Runs just after a falling edge: decides what the slave presents at the
    // next rising edge. DUT outputs are stable here, so a handshake seen now
    // is the one that happens on that rising edge.
    task automatic slave_step();
        bit aw_now, w_now, ar_now;
        aw_now = 0; w_now = 0; ar_now = 0;

        if (b_hs_next) begin
            m_axil_bvalid = 1'b0;
            b_hs_next = 0;
        end else if (b_pending && !m_axil_bvalid) begin
            if (b_wait >= b_delay) begin
                m_axil_bvalid = 1'b1;
                m_axil_bresp  = bresp_cfg;
            end else b_wait++;
        end
        if (m_axil_bvalid && m_axil_bready) begin
            b_hs_next = 1; b_pending = 0; b_cnt++;
        end

        if (r_hs_next) begin
            m_axil_rvalid = 1'b0;
            r_hs_next = 0;
        end else if (r_pending && !m_axil_rvalid) begin
            if (r_wait >= r_delay) begin
                m_axil_rvalid = 1'b1;
                m_axil_rdata  = rdata_cfg;
                m_axil_rresp  = rresp_cfg;
            end else r_wait++;
        end
        if (m_axil_rvalid && m_axil_rready) begin
            r_hs_next = 1; r_pending = 0; r_cnt++;
        end

        if (prev_awvalid && !prev_aw_hs && (!m_axil_awvalid || m_axil_awaddr != prev_awaddr)) stable_viol++;
        if (prev_wvalid  && !prev_w_hs  && (!m_axil_wvalid  || m_axil_wdata  != prev_wdata))  stable_viol++;
        if (prev_arvalid && !prev_ar_hs && (!m_axil_arvalid || m_axil_araddr != prev_araddr)) stable_viol++;

        m_axil_awready = 1'b0;
        if (m_axil_awvalid) begin
            if (aw_wait >= aw_delay) begin
                m_axil_awready = 1'b1; aw_now = 1; aw_cnt++; seen_awaddr = m_axil_awaddr;
            end else aw_wait++;
        end
        m_axil_wready = 1'b0;
        if (m_axil_wvalid) begin
            if (w_wait >= w_delay) begin
                m_axil_wready = 1'b1; w_now = 1; w_cnt++;
                seen_wdata = m_axil_wdata; seen_wstrb = m_axil_wstrb;
            end else w_wait++;
        end
        if ((aw_now || w_now) && aw_cnt == 1 && w_cnt == 1) begin
            b_pending = 1; b_wait = 0;
        end
        m_axil_arready = 1'b0;
        if (m_axil_arvalid) begin
            if (ar_wait >= ar_delay) begin
                m_axil_arready = 1'b1; ar_now = 1; ar_cnt++; seen_araddr = m_axil_araddr;
                r_pending = 1; r_wait = 0;
            end else ar_wait++;
        end

        prev_awvalid = m_axil_awvalid; prev_aw_hs = aw_now; prev_awaddr = m_axil_awaddr;
        prev_wvalid  = m_axil_wvalid;  prev_w_hs  = w_now;  prev_wdata  = m_axil_wdata;
        prev_arvalid = m_axil_arvalid; prev_ar_hs = ar_now; prev_araddr = m_axil_araddr;
    endtask

    task automatic tick();
        @(negedge aclk);
        cyc++;
        slave_step();
        if (write_start_ack) begin n_wack++; wack_cyc = cyc; write_start = 1'b0; end
        if (read_start_ack)  begin n_rack++; rack_cyc = cyc; read_start  = 1'b0; end
        if ((write_start_ack || read_start_ack) && !write_start && !read_start) begin
            reg_addr  = {$urandom, $urandom};
            reg_wdata = $urandom;
        end
        if (write_done) begin n_wdone++; wdone_cyc = cyc; end
        if (read_done)  begin n_rdone++; rdone_cyc = cyc; rdata_at_done = reg_rdata; end
        if ((write_done || read_done) && (write_start_ack || read_start_ack)) overlap++;
    endtask

    function automatic bit out_any();
        return |{write_start_ack, read_start_ack, reg_rdata, write_done, read_done, resp_err,
                 timeout_err, m_axil_awaddr, m_axil_awvalid, m_axil_wdata, m_axil_wstrb,
                 m_axil_wvalid, m_axil_bready, m_axil_araddr, m_axil_arvalid, m_axil_rready,
                 m_axil_awprot, m_axil_arprot};
    endfunction

    function automatic bit bus_idle();
        return !(m_axil_awvalid || m_axil_wvalid || m_axil_bready || m_axil_arvalid || m_axil_rready);
    endfunction

    task automatic model_reset();
        resp_err_m = 0; timeout_err_m = 0; rdata_m = '0;
    endtask

    // One complete request with the current slave configuration, checked
    // against the predicted outcome.
    task automatic run_txn(input string tag, input bit is_wr,
                           input logic [63:0] addr, input logic [31:0] wd);
        bit exp_to;
        int budget;
        int start_cyc;
        slave_clear();
        exp_to = is_wr ? (aw_delay >= NEVER || w_delay >= NEVER || b_delay >= NEVER)
                       : (ar_delay >= NEVER || r_delay >= NEVER);
        reg_addr  = addr;
        reg_wdata = wd;
        start_cyc = cyc;
        if (is_wr) write_start = 1'b1;
        else       read_start  = 1'b1;
        budget = BUDGET;
        while (n_wdone + n_rdone == 0 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (3) tick();

        if (exp_to) timeout_err_m = 1;
        if (is_wr) begin
            if (!exp_to && bresp_cfg != RESP_OKAY) resp_err_m = 1;
        end else begin
            rdata_m = exp_to ? RD_TIMEOUT_DATA : rdata_cfg;
            if (!exp_to && rresp_cfg != RESP_OKAY) resp_err_m = 1;
        end

        check({tag, "_ack_latency"}, (is_wr ? wack_cyc : rack_cyc) - start_cyc, 1);
        check({tag, "_wr_ack"},  n_wack,  is_wr);
        check({tag, "_rd_ack"},  n_rack,  !is_wr);
        check({tag, "_wr_done"}, n_wdone, is_wr);
        check({tag, "_rd_done"}, n_rdone, !is_wr);
        if (is_wr) begin
            check({tag, "_aw_count"}, aw_cnt, aw_delay < NEVER);
            check({tag, "_w_count"},  w_cnt,  w_delay < NEVER);
            if (aw_delay < NEVER) check({tag, "_awaddr"}, seen_awaddr, addr);
            if (w_delay < NEVER) begin
                check({tag, "_wdata"}, seen_wdata, wd);
                check({tag, "_wstrb"}, seen_wstrb, 4'hF);
            end
        end else begin
            check({tag, "_ar_count"}, ar_cnt, ar_delay < NEVER);
            if (ar_delay < NEVER) check({tag, "_araddr"}, seen_araddr, addr);
            check({tag, "_rdata_at_done"}, rdata_at_done, rdata_m);
        end
        check({tag, "_rdata_held"}, reg_rdata, rdata_m);
        check({tag, "_resp_err"}, resp_err, resp_err_m);
        check({tag, "_timeout_err"}, timeout_err, timeout_err_m);
        if (!exp_to) check({tag, "_valid_stable"}, stable_viol, 0);
        check({tag, "_bus_idle"}, bus_idle(), 1);
    endtask

    initial begin
        logic [63:0] both_addr;
        int budget;
        aresetn = 1'b0; write_start = 1'b0; read_start = 1'b0;
        reg_addr = '0; reg_wdata = '0; cyc = 0;
        bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY; rdata_cfg = '0;
        set_delays(0, 0, 0, 0, 0);
        slave_clear();
        model_reset();

        repeat (3) tick();
        check("reset_outputs_zero", out_any(), 0);
        aresetn = 1'b1;
        tick();
        check("post_reset_outputs_zero", out_any(), 0);

        // Write with an always-ready slave.
        set_delays(0, 0, 0, 0, 0);
        run_txn("wr_basic", 1, 64'h4_0000_0004, 32'h0000_0001);

        // Read with AR and R delays; arvalid must stay up until accepted.
        set_delays(0, 0, 0, 3, 5);
        rdata_cfg = 32'h0010_1234;
        run_txn("rd_delay", 0, 64'h0000_0002_0000_0100, 32'h0);

        // W channel accepted well before AW.
        set_delays(4, 0, 1, 0, 0);
        run_txn("wr_skew", 1, 64'h0000_0000_0000_0A00, 32'hDEAD_BEEF);

        // Simultaneous requests: write wins, read follows after DONE.
        slave_clear();
        set_delays(0, 0, 0, 0, 0);
        rdata_cfg = 32'hA5A5_0001;
        both_addr = 64'h0000_0001_0000_0010;
        reg_addr = both_addr; reg_wdata = 32'hCAFE_F00D;
        write_start = 1'b1; read_start = 1'b1;
        budget = BUDGET;
        while (n_rdone == 0 && budget > 0) begin tick(); budget--; end
        repeat (2) tick();
        rdata_m = rdata_cfg;
        check("both_wr_ack", n_wack, 1);
        check("both_rd_ack", n_rack, 1);
        check("both_wr_first", wdone_cyc < rack_cyc, 1);
        check("both_ack_gap_ge4", (rack_cyc - wack_cyc) >= 4, 1);
        check("both_done_ack_overlap", overlap, 0);
        check("both_awaddr", seen_awaddr, both_addr);
        check("both_wdata", seen_wdata, 32'hCAFE_F00D);
        check("both_araddr", seen_araddr, both_addr);
        check("both_rdata", rdata_at_done, rdata_m);

        // Error response, then a read whose R never arrives.
        set_delays(0, 0, 0, 0, 0);
        bresp_cfg = RESP_SLVERR;
        run_txn("wr_slverr", 1, 64'h0000_0000_0000_0040, 32'h1234_5678);
        bresp_cfg = RESP_OKAY;
        set_delays(0, 0, 0, 0, NEVER);
        run_txn("rd_timeout", 0, 64'h0000_0000_0000_0044, 32'h0);
        check("rd_timeout_latency", rdone_cyc - rack_cyc, TIMEOUT + 1);

        // Reset while waiting for R; a fresh read must then work.
        slave_clear();
        set_delays(0, 0, 0, 0, NEVER);
        reg_addr = 64'h0000_0000_0000_0080;
        read_start = 1'b1;
        budget = BUDGET;
        while (!m_axil_rready && budget > 0) begin tick(); budget--; end
        check("rst_mid_in_rd_resp", m_axil_rready, 1);
        repeat (2) tick();
        aresetn = 1'b0;
        #1;
        check("rst_mid_outputs_zero", out_any(), 0);
        repeat (3) tick();
        check("rst_mid_no_done", n_rdone, 0);
        aresetn = 1'b1;
        read_start = 1'b0;
        model_reset();
        set_delays(0, 0, 0, 1, 2);
        rdata_cfg = 32'h0BAD_CAFE;
        run_txn("rd_after_rst", 0, 64'h0000_0000_0000_0084, 32'h0);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            bit is_wr;
            int pick;
            is_wr = $urandom_range(0, 1) == 1;
            set_delays($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6),
                       $urandom_range(0, 6), $urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) begin
                pick = $urandom_range(0, 4);
                case (pick)
                    0: aw_delay = NEVER;
                    1: w_delay  = NEVER;
                    2: b_delay  = NEVER;
                    3: ar_delay = NEVER;
                    default: r_delay = NEVER;
                endcase
            end
            pick = $urandom_range(0, 7);
            bresp_cfg = (pick == 0) ? RESP_SLVERR : (pick == 1) ? RESP_DECERR : RESP_OKAY;
            pick = $urandom_range(0, 7);
            rresp_cfg = (pick == 0) ? RESP_DECERR : (pick == 1) ? RESP_SLVERR : RESP_OKAY;
            rdata_cfg = $urandom;
            run_txn(is_wr ? "rand_wr" : "rand_rd", is_wr, {$urandom, $urandom}, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
